// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand interlock and taken-branch flush sequencer
// for the dual-slot VLIW front end, with a saturating bubble-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rsc,
    input  logic             id_use_rs2,
    input  logic             id_use_rsc,
    input  logic             id_is_br,
    input  logic             id_is_cbr,
    input  logic             id_br_taken,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_regdest,
    input  logic             ex_regwrc,
    input  logic [4:0]       ex_regdestc,
    input  logic             mem_memrd,
    input  logic [4:0]       mem_regdest,
    input  logic             ext_stall,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             pc_sel_br,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, STALL, HOLD} state_t;
    typedef enum logic [1:0] {M_ADV, M_BUB, M_FLUSH, M_FRZ} mode_t;

    state_t     state, state_nx;
    mode_t      mode;
    logic [1:0] cnt, cnt_nx;
    logic [1:0] len, len_br, len_cbr;
    logic       load_use, ex_alu, taken;

    function automatic logic hit(input logic [4:0] s, input logic [4:0] d, input logic f);
        return f && (s != 5'd0) && (s == d);
    endfunction

    // An ID-resolved branch needs its operand from the register file or forwarding
    // out of EX/MEM; a load still in EX is two cycles away from being usable.
    function automatic logic [1:0] br_len(
        input logic [4:0] r, input logic [4:0] exd, input logic exld, input logic exalu,
        input logic [4:0] exdc, input logic exwc, input logic [4:0] memd, input logic memld
    );
        return hit(r, exd, exld) ? 2'd2 :
               (hit(r, exd, exalu) || hit(r, exdc, exwc) || hit(r, memd, memld)) ? 2'd1 : 2'd0;
    endfunction

    always_comb begin
        ex_alu   = ex_regwr && !ex_memrd;
        load_use = ex_memrd && (hit(id_rs1, ex_regdest, 1'b1) ||
                   (id_use_rs2 && hit(id_rs2, ex_regdest, 1'b1)) ||
                   (id_use_rsc && hit(id_rsc, ex_regdest, 1'b1)));
        len_br   = 2'd0;
        len_cbr  = 2'd0;
        if (id_is_br) begin
            len_br = br_len(id_rs1, ex_regdest, ex_memrd, ex_alu, ex_regdestc, ex_regwrc,
                            mem_regdest, mem_memrd);
            if (id_use_rs2 && br_len(id_rs2, ex_regdest, ex_memrd, ex_alu, ex_regdestc,
                                     ex_regwrc, mem_regdest, mem_memrd) > len_br)
                len_br = br_len(id_rs2, ex_regdest, ex_memrd, ex_alu, ex_regdestc, ex_regwrc,
                                mem_regdest, mem_memrd);
        end
        if (id_is_cbr)
            len_cbr = br_len(id_rsc, ex_regdest, ex_memrd, ex_alu, ex_regdestc, ex_regwrc,
                             mem_regdest, mem_memrd);
        len = {1'b0, load_use};
        if (len_br > len)
            len = len_br;
        if (len_cbr > len)
            len = len_cbr;
        if (!id_valid)
            len = 2'd0;
        taken = id_valid && (id_is_br || id_is_cbr) && id_br_taken;
    end

    // HOLD with ext_stall low behaves exactly like RUN, so hazards are re-evaluated
    // in the first cycle after the freeze.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode     = M_ADV;
        if (state == STALL) begin
            if (ext_stall) begin
                mode = M_FRZ;
            end else begin
                mode     = M_BUB;
                cnt_nx   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                state_nx = (cnt <= 2'd1) ? RUN : STALL;
            end
        end else if (ext_stall) begin
            mode     = M_FRZ;
            state_nx = HOLD;
        end else if (len != 2'd0) begin
            mode     = M_BUB;
            cnt_nx   = len - 2'd1;
            state_nx = (len > 2'd1) ? STALL : RUN;
        end else begin
            state_nx = RUN;
            mode     = taken ? M_FLUSH : M_ADV;
        end
    end

    always_comb begin
        pc_en       = rst_n && (mode == M_ADV || mode == M_FLUSH);
        ifid_en     = rst_n && (mode == M_ADV || mode == M_FLUSH);
        pc_sel_br   = rst_n && (mode == M_FLUSH);
        ifid_flush  = !rst_n || (mode == M_FLUSH);
        idex_en     = rst_n && (mode != M_FRZ);
        idex_bubble = !rst_n || (mode == M_BUB);
        busy        = rst_n && (state != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (perf_clr)
            stall_cycles <= '0;
        else if (idex_bubble && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan scenarios plus randomized traffic, checked by a
// scoreboard against a bubbles-owed reference model.
module tb_hazard_ctrl;
    logic clk = 0, rst_n = 0;
    logic id_valid, id_use_rs2, id_use_rsc, id_is_br, id_is_cbr, id_br_taken;
    logic [4:0] id_rs1, id_rs2, id_rsc, ex_regdest, ex_regdestc, mem_regdest;
    logic ex_regwr, ex_memrd, ex_regwrc, mem_memrd, ext_stall, perf_clr;
    logic pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en, idex_bubble, busy;
    logic [15:0] stall_cycles;

    typedef struct { logic [6:0] o; logic [15:0] c; } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;
    int pending = 0, mcnt = 0;
    bit hold = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rsc(id_rsc), .id_use_rs2(id_use_rs2), .id_use_rsc(id_use_rsc),
        .id_is_br(id_is_br), .id_is_cbr(id_is_cbr), .id_br_taken(id_br_taken),
        .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_regdest(ex_regdest),
        .ex_regwrc(ex_regwrc), .ex_regdestc(ex_regdestc), .mem_memrd(mem_memrd),
        .mem_regdest(mem_regdest), .ext_stall(ext_stall), .perf_clr(perf_clr),
        .pc_en(pc_en), .pc_sel_br(pc_sel_br), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble), .busy(busy), .stall_cycles(stall_cycles)
    );

    function automatic bit m(input logic [4:0] s, input logic [4:0] d, input logic f);
        return f && s != 0 && s == d;
    endfunction

    // Bubbles a branch operand needs: EX load 2, any other pending producer 1.
    function automatic int opnd(input logic [4:0] r);
        if (m(r, ex_regdest, ex_memrd)) return 2;
        if (m(r, ex_regdest, ex_regwr && !ex_memrd) || m(r, ex_regdestc, ex_regwrc) ||
            m(r, mem_regdest, mem_memrd)) return 1;
        return 0;
    endfunction

    function automatic int need();
        int l = 0;
        if (!id_valid) return 0;
        if (ex_memrd && (m(id_rs1, ex_regdest, 1) || (id_use_rs2 && m(id_rs2, ex_regdest, 1)) ||
            (id_use_rsc && m(id_rsc, ex_regdest, 1)))) l = 1;
        if (id_is_br) begin
            if (opnd(id_rs1) > l) l = opnd(id_rs1);
            if (id_use_rs2 && opnd(id_rs2) > l) l = opnd(id_rs2);
        end
        if (id_is_cbr && opnd(id_rsc) > l) l = opnd(id_rsc);
        return l;
    endfunction

    // Expected order: {pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en, idex_bubble, busy}
    task automatic issue();
        exp_t e;
        int l;
        bit bub = 0;
        if (!rst_n) begin
            pending = 0; hold = 0; mcnt = 0;
            e.o = 7'b0001010; e.c = 0;
        end else begin
            e.c = 16'(mcnt);
            l = need();
            e.o[0] = (pending > 0) || hold;
            if (ext_stall) begin
                e.o[6:1] = 6'b000000;
                hold = (pending == 0);
            end else begin
                hold = 0;
                if (pending > 0) begin
                    bub = 1; pending--;
                end else if (l > 0) begin
                    bub = 1; pending = l - 1;
                end
                if (bub) e.o[6:1] = 6'b000011;
                else if (id_valid && (id_is_br || id_is_cbr) && id_br_taken) e.o[6:1] = 6'b111110;
                else e.o[6:1] = 6'b101010;
            end
            if (perf_clr) mcnt = 0;
            else if (bub && mcnt < 65535) mcnt++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_valid, id_use_rs2, id_use_rsc, id_is_br, id_is_cbr, id_br_taken} = '0;
        {id_rs1, id_rs2, id_rsc, ex_regdest, ex_regdestc, mem_regdest} = '0;
        {ex_regwr, ex_memrd, ex_regwrc, mem_memrd, ext_stall, perf_clr} = '0;
    endtask

    task automatic br_on_load();
        idle();
        ex_regwr = 1; ex_memrd = 1; ex_regdest = 7;
        id_valid = 1; id_is_br = 1; id_rs1 = 7; id_br_taken = 1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en, idex_bubble, busy} !== e.o) begin
                fails++;
                $display("FAIL ctrl t=%0t got %b exp %b", $time,
                         {pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en, idex_bubble, busy}, e.o);
            end
            tests++;
            if (stall_cycles !== e.c) begin
                fails++;
                $display("FAIL stall_cycles t=%0t got %h exp %h", $time, stall_cycles, e.c);
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        issue();
        issue();
        rst_n = 1;
        issue();
        // load-use: lw x5 in EX, add x5 in ID
        ex_regwr = 1; ex_memrd = 1; ex_regdest = 5; id_valid = 1; id_rs1 = 5;
        issue();
        idle(); id_valid = 1; id_rs1 = 5;
        issue();
        // branch on an EX load: two bubbles then flush
        br_on_load();
        issue();
        ex_regwr = 0; ex_memrd = 0; ex_regdest = 0; mem_memrd = 1; mem_regdest = 7;
        issue();
        mem_memrd = 0; mem_regdest = 0;
        issue();
        // compressed branch on compressed ALU write
        idle(); ex_regwrc = 1; ex_regdestc = 9; id_valid = 1; id_is_cbr = 1; id_rsc = 9;
        issue();
        ex_regwrc = 0;
        issue();
        // x0 never matches
        idle(); ex_regwr = 1; ex_memrd = 1; id_valid = 1; id_use_rs2 = 1; id_use_rsc = 1;
        issue();
        // ext_stall for 3 cycles inside a 2-cycle stall
        br_on_load();
        issue();
        idle(); ext_stall = 1;
        repeat (3) issue();
        ext_stall = 0;
        issue();
        issue();
        // ext_stall from RUN then release into a hazard
        ext_stall = 1;
        repeat (2) issue();
        br_on_load();
        issue();
        // reset in the middle of the resulting stall
        rst_n = 0;
        issue();
        rst_n = 1; idle(); id_valid = 1;
        issue();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rsc = 5'($urandom_range(0, 3));
            id_use_rs2 = 1'($urandom); id_use_rsc = 1'($urandom);
            id_is_br = ($urandom_range(0, 2) == 0); id_is_cbr = ($urandom_range(0, 3) == 0);
            id_br_taken = 1'($urandom);
            ex_regwr = 1'($urandom); ex_memrd = ($urandom_range(0, 2) == 0);
            ex_regdest = 5'($urandom_range(0, 3)); ex_regwrc = 1'($urandom);
            ex_regdestc = 5'($urandom_range(0, 3)); mem_memrd = ($urandom_range(0, 2) == 0);
            mem_regdest = 5'($urandom_range(0, 3));
            ext_stall = ($urandom_range(0, 5) == 0); perf_clr = ($urandom_range(0, 49) == 0);
            issue();
        end
        // saturate the counter with back-to-back load-use stalls
        rst_n = 1; idle(); perf_clr = 1;
        issue();
        perf_clr = 0; ex_memrd = 1; ex_regdest = 3; id_valid = 1; id_rs1 = 3;
        repeat (65540) issue();
        perf_clr = 1;
        issue();
        perf_clr = 0;
        repeat (2) issue();
        idle();
        issue();
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and flush sequencer for the dual-slot VLIW core, with one main slot and one compressed slot per bundle. It decides each cycle whether the bundle in ID may advance, must be held with a bubble inserted into EX, or must be squashed after a taken branch/jump resolved in ID. It complements the forwarding unit: it inserts only the stalls that forwarding cannot cover (load-use and branch-operand hazards) and sequences multi-cycle stalls with an explicit state machine.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real bundle
- id_rs1, id_rs2  in  5 each  main-slot sources
- id_rsc  in  5  compressed-slot source
- id_use_rs2  in  1  main slot reads rs2
- id_use_rsc  in  1  compressed slot reads rsc
- id_is_br  in  1  main slot is a branch/jump resolved in ID (reads rs1, and rs2 if id_use_rs2)
- id_is_cbr  in  1  compressed slot is a branch resolved in ID (reads rsc)
- id_br_taken  in  1  ID branch/jump outcome is taken (valid only when operands are ready)
- ex_regwr, ex_memrd  in  1 each  EX main slot writes a register / is a load
- ex_regdest  in  5  EX main-slot destination
- ex_regwrc  in  1  EX compressed slot writes a register (ALU only, never a load)
- ex_regdestc  in  5  EX compressed-slot destination
- mem_memrd  in  1  MEM main slot is a load
- mem_regdest  in  5  MEM main-slot destination
- ext_stall  in  1  memory not ready; freeze the entire front end
- perf_clr  in  1  synchronous clear of stall_cycles
- pc_en  out  1  PC may update
- pc_sel_br  out  1  PC loads the ID branch target
- ifid_en  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_en  out  1  ID/EX register may load
- idex_bubble  out  1  ID/EX loads a NOP
- busy  out  1  state is not RUN
- stall_cycles  out  CNT_W  count of bubble cycles, saturating

## Operation
- A source match means that a register index is nonzero and equal to a destination whose write or load flag is set. Register 0 never matches.
- Used sources: rs1 always; rs2 if id_use_rs2; rsc if id_use_rsc.
- The required stall length L (0, 1 or 2) is the maximum of the applicable terms below. All terms require id_valid.
  - Load-use: ex_memrd and ex_regdest matches any used source. L=1.
  - Main branch (id_is_br), operand rs1 or rs2:
    - EX ALU writer (ex_regwr and not ex_memrd, or ex_regwrc) matches → L=1.
    - EX load matches → L=2.
    - mem_memrd and mem_regdest matches → L=1.
  - Compressed branch (id_is_cbr), operand rsc: the same three rules as the main branch.
- The FSM has three states: RUN, STALL, HOLD.
- RUN:
  - ext_stall: go to HOLD and freeze.
  - Otherwise, if L>0: assert the stall outputs this cycle and load cnt=L-1. Go to STALL if cnt>0, else stay in RUN and re-evaluate next cycle.
  - Otherwise, if id_valid and (id_is_br or id_is_cbr) and id_br_taken: assert the flush outputs this cycle.
  - Otherwise: assert the advance outputs.
- STALL: assert the stall outputs and decrement cnt, without re-evaluating hazards. When cnt reaches 0, go to RUN. ext_stall pauses cnt and asserts the freeze outputs, but the state stays STALL.
- HOLD: assert the freeze outputs while ext_stall is high. Return to RUN on the first cycle ext_stall is low, and re-evaluate hazards in that cycle.
- Output sets (signals not listed are 0):
  - Advance: pc_en, ifid_en, idex_en.
  - Stall: idex_en, idex_bubble.
  - Flush: pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en.
  - Freeze: all enables 0, no bubble, no flush.
- Priority: reset > ext_stall > hazard stall > taken-branch flush. A branch whose operands are not ready is never flushed on.
- stall_cycles increments on every clock where idex_bubble=1 and holds at all-ones. perf_clr takes priority over the increment.

## Timing
- Outputs are combinational from the state and the current inputs, so a stall takes effect in the cycle it is detected. State and cnt are registered.
- Reset, asynchronous and held while rst_n=0:
  - state=RUN, cnt=0, stall_cycles=0.
  - pc_en=0, ifid_en=0, idex_en=0, pc_sel_br=0.
  - ifid_flush=1, idex_bubble=1, busy=0.
- Reset released mid-stall: resume in RUN with no residual stall.
- Stall latency is exactly L bubble cycles, plus any cycles ext_stall adds.
- ext_stall asserted during the last STALL cycle: the bubble is deferred, and the STALL cycle completes after ext_stall drops.
- Flush lasts 1 cycle per taken branch; the next bundle in ID is the NOP.

## Test plan
- Load-use: EX is lw x5; ID is add rs1=x5. Expect 1 bubble cycle (pc_en=0, idex_bubble=1), then advance; stall_cycles=1.
- Branch on an EX load: EX is lw x7; ID is beq rs1=x7. Expect 2 consecutive bubbles and busy=1 in the second; the branch is then taken, giving pc_sel_br=1 and ifid_flush=1 for 1 cycle; stall_cycles=2.
- Compressed branch on an EX compressed ALU write: ex_regwrc=1, ex_regdestc=x9; ID has id_is_cbr=1, rsc=x9. Expect 1 bubble.
- Register 0: EX is lw x0; ID reads x0. Expect no stall and an advance.
- ext_stall asserted for 3 cycles during a 2-cycle STALL: expect freeze for 3 cycles, then the remaining bubble, with exactly 2 bubble cycles in total.
- Saturation: preset stall_cycles to 16'hFFFF by continuous stalls; it holds at FFFF. perf_clr gives 0 on the next edge, even during a bubble.
